addr_serial_capture: RTL and testbench
======================================

Name: addr_serial_capture

Overview:
- Captures a parallel bus through serial links, as used to read the address bus over a reduced pin count.
- Models per-lane 8-bit parallel-in/serial-out shift registers (74LS165 style).
- A sequencer drives the shared shift/load and serial-clock lines.
- Per-lane serial-in deserializers rebuild the word and flag completion.

Parameters:
- LANES, 2, number of independent 8-bit serial lanes.
- LANE_WIDTH, 8, bits per lane (shift-register length).
- Data width W = LANES*LANE_WIDTH (16 by default).
- Lane 0 carries the most significant byte: i_par[15:8] in and o_data[15:8] out.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle pulse; re-arms a new capture when in DONE.
- i_par  in  W  parallel source word, sampled at the load edge only.
- o_shld  out  1  shift/load, active low; low for exactly one cycle per capture.
- o_serclk  out  1  serial clock, one high cycle per transferred bit.
- o_ser  out  LANES  serial line per lane (MSB of each lane shift register).
- o_data  out  W  reassembled word.
- o_done  out  1  high while o_data holds a complete capture.
- o_busy  out  1  high in states LOAD, SHIFT_LO and SHIFT_HI.

Behaviour:
- Reset state, asynchronous, while reset=1:
  - state START, o_shld=1, o_serclk=0, o_done=0, o_busy=0;
  - o_data=0, bit counter=0, lane shift registers=0.
- States: START, LOAD, SHIFT_LO, SHIFT_HI, DONE.
- All outputs are registered except o_ser.
- START: the first rising edge after reset release enters LOAD. Capture is automatic; no i_start is needed.
- LOAD (1 cycle):
  - o_shld=0 and o_busy=1;
  - on the exiting edge each lane shift register loads its byte of i_par;
  - on the same edge the deserializers are cleared to 0;
  - next state SHIFT_LO.
- SHIFT_LO (1 cycle): o_shld=1, o_serclk=0; next state SHIFT_HI.
- SHIFT_HI (1 cycle), o_serclk=1. On the exiting edge:
  - each deserializer shifts left and takes the current o_ser bit as its LSB;
  - each lane shift register shifts left with 0 fill;
  - the bit counter increments.
  - If the counter reaches LANE_WIDTH: go to DONE. Otherwise: go to SHIFT_LO.
- Bit order is MSB first: o_ser[k] after load equals the lane k bit 7.
- DONE:
  - o_done=1, o_busy=0, o_serclk=0, o_shld=1;
  - o_data is held stable indefinitely;
  - i_start=1 clears o_done and enters LOAD.
- i_start is ignored in every state except DONE.
- Latency: o_done rises after the 18th rising edge following reset release. The count is 1 + 1 + 2*LANE_WIDTH edges.
- i_par changes after the load edge have no effect on the current capture.
- During shifting, o_data shows partial, left-aligned progress. It is valid only while o_done=1.
- Reset asserted mid-capture aborts immediately to reset values; the sequence restarts after release.

Test Plan:
- i_par=0xAA55, release reset:
  - o_shld low for exactly 1 cycle, then 8 o_serclk pulses;
  - o_done=1 after edge 18 and o_data=0xAA55;
  - o_ser[0] reads 1,0,1,0,1,0,1,0 and o_ser[1] reads 0,1,0,1,0,1,0,1 at each SHIFT_HI.
- i_par=0xFFFF, then 0x0000, each run from reset -> o_data equals i_par and o_done=1 at edge 18.
- i_par=0x1234 at load, changed to 0xFFFF during shifting -> o_data=0x1234.
- After DONE with 0xAA55, set i_par=0x5A3C and pulse i_start:
  - o_done drops the next cycle;
  - o_data=0x5A3C and o_done=1 exactly 17 edges after the i_start edge.
- Pulse i_start during shifting -> no effect; completion timing is unchanged.
- Assert reset after the 3rd serial bit -> all outputs return to reset values asynchronously; after release, a full capture yields the correct word at edge 18.

Source files
------------

// File: rtl/addr_serial_capture.sv
// addr_serial_capture
//   Reads a parallel bus over a reduced pin count. Each lane models an
//   8-bit parallel-in/serial-out shift register (74LS165 style). A
//   sequencer drives the shared shift/load and serial-clock lines, and one
//   deserializer per lane rebuilds the word from the serial stream.
//
// Ports
//   clk       system clock, rising-edge active
//   reset     asynchronous, active-high reset
//   i_start   single-cycle pulse; re-arms a capture while in DONE
//   i_par     parallel source word (W bits), sampled on the load edge only
//   o_shld    shift/load, active low, low for one cycle per capture
//   o_serclk  serial clock, one high cycle per transferred bit
//   o_ser     serial line per lane (MSB of that lane's shift register)
//   o_data    reassembled word (lane 0 in the top byte)
//   o_done    high while o_data holds a complete capture
//   o_busy    high in LOAD, SHIFT_LO and SHIFT_HI
module addr_serial_capture #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned LANE_WIDTH = 8,
  localparam int unsigned W         = LANES * LANE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [W-1:0]     i_par,
  output logic             o_shld,
  output logic             o_serclk,
  output logic [LANES-1:0] o_ser,
  output logic [W-1:0]     o_data,
  output logic             o_done,
  output logic             o_busy
);

  localparam int unsigned CW = $clog2(LANE_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_START,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } state_t;

  state_t state, state_next;

  // Packed index i maps to o_data[i*LANE_WIDTH +: LANE_WIDTH], so lane k
  // (lane 0 = most significant byte) lives at index LANES-1-k.
  logic [LANES-1:0][LANE_WIDTH-1:0] sreg;
  logic [LANES-1:0][LANE_WIDTH-1:0] deser;
  logic [CW-1:0]                    bit_cnt;

  logic shld_next, serclk_next, done_next, busy_next;

  always_comb begin
    state_next = state;
    case (state)
      ST_START:    state_next = ST_LOAD;
      ST_LOAD:     state_next = ST_SHIFT_LO;
      ST_SHIFT_LO: state_next = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (bit_cnt == CW'(LANE_WIDTH - 1)) state_next = ST_DONE;
        else                                state_next = ST_SHIFT_LO;
      end
      ST_DONE:     if (i_start) state_next = ST_LOAD;
      default:     state_next = ST_START;
    endcase
  end

  // Outputs are registered: decode them from the next state so they line
  // up with the state they describe.
  always_comb begin
    shld_next   = (state_next != ST_LOAD);
    serclk_next = (state_next == ST_SHIFT_HI);
    done_next   = (state_next == ST_DONE);
    busy_next   = (state_next == ST_LOAD) || (state_next == ST_SHIFT_LO) ||
                  (state_next == ST_SHIFT_HI);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_START;
      o_shld   <= 1'b1;
      o_serclk <= 1'b0;
      o_done   <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_next;
      o_shld   <= shld_next;
      o_serclk <= serclk_next;
      o_done   <= done_next;
      o_busy   <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg    <= '0;
      deser   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          sreg    <= i_par;
          deser   <= '0;
          bit_cnt <= '0;
        end
        ST_SHIFT_HI: begin
          for (int unsigned i = 0; i < LANES; i++) begin
            deser[i] <= {deser[i][LANE_WIDTH-2:0], sreg[i][LANE_WIDTH-1]};
            sreg[i]  <= {sreg[i][LANE_WIDTH-2:0], 1'b0};
          end
          bit_cnt <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ser = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      o_ser[k] = sreg[LANES-1-k][LANE_WIDTH-1];
    end
  end

  assign o_data = deser;

endmodule

// File: tb/tb_addr_serial_capture.sv
module tb_addr_serial_capture;

  localparam int LANES = 2;
  localparam int LW    = 8;
  localparam int W     = LANES * LW;

  logic             clk;
  logic             reset;
  logic             i_start;
  logic [W-1:0]     i_par;
  logic             o_shld;
  logic             o_serclk;
  logic [LANES-1:0] o_ser;
  logic [W-1:0]     o_data;
  logic             o_done;
  logic             o_busy;

  int checks = 0;
  int errors = 0;

  addr_serial_capture #(
    .LANES      (LANES),
    .LANE_WIDTH (LW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_start  (i_start),
    .i_par    (i_par),
    .o_shld   (o_shld),
    .o_serclk (o_serclk),
    .o_ser    (o_ser),
    .o_data   (o_data),
    .o_done   (o_done),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " shld"},   32'(o_shld),   32'd1);
    check({tag, " serclk"}, 32'(o_serclk), 32'd0);
    check({tag, " done"},   32'(o_done),   32'd0);
    check({tag, " busy"},   32'(o_busy),   32'd0);
    check({tag, " data"},   32'(o_data),   32'd0);
    check({tag, " ser"},    32'(o_ser),    32'd0);
  endtask

  // Reference behaviour, counted from the edge that enters LOAD (edge 0):
  // odd edges 1..15 show SHIFT_LO, even edges 2..16 show SHIFT_HI carrying
  // bit (e-2)/2 of each lane MSB first, edge 17 shows DONE with the word
  // that was on i_par at edge 1 (the load edge).
  task automatic monitor_capture(input logic [W-1:0] exp_word, input logic [W-1:0] par_late,
                                 input bit change_par, input bit pulse_start, input string tag);
    int pulses    = 0;
    int shld_low  = 0;
    int pat_err   = 0;
    int busy_cnt  = 1;
    int done_edge = -1;
    logic [W-1:0] w;
    w = exp_word;
    check({tag, " load shld"}, 32'(o_shld), 32'd0);
    check({tag, " load busy"}, 32'(o_busy), 32'd1);
    check({tag, " load done"}, 32'(o_done), 32'd0);
    for (int e = 1; e <= 40 && done_edge < 0; e++) begin
      i_start = pulse_start && (e == 6);
      tick();
      i_start = 1'b0;
      if (e == 1 && change_par) i_par = par_late;
      if (o_done) begin
        done_edge = e;
      end else begin
        if (o_serclk !== ((e % 2) == 0)) pat_err++;
        if (!o_shld) shld_low++;
        if (o_busy) busy_cnt++;
        if (o_serclk && pulses < LW) begin
          for (int k = 0; k < LANES; k++) begin
            check($sformatf("%s ser lane%0d bit%0d", tag, k, pulses),
                  32'(o_ser[k]), 32'(w[W-1-k*LW-pulses]));
          end
        end
        if (o_serclk) pulses++;
      end
    end
    check({tag, " done edge"},     32'(done_edge), 32'd17);
    check({tag, " serclk pulses"}, 32'(pulses),    32'(LW));
    check({tag, " serclk timing"}, 32'(pat_err),   32'd0);
    check({tag, " extra shld low"},32'(shld_low),  32'd0);
    check({tag, " busy cycles"},   32'(busy_cnt),  32'd17);
    check({tag, " data"},          32'(o_data),    32'(exp_word));
    check({tag, " done busy"},     32'(o_busy),    32'd0);
    check({tag, " done shld"},     32'(o_shld),    32'd1);
    check({tag, " done serclk"},   32'(o_serclk),  32'd0);
  endtask

  // Applies reset, checks reset/START values, releases, and takes the first
  // edge (which enters LOAD).
  task automatic reset_and_go(input logic [W-1:0] par, input string tag);
    reset   = 1'b1;
    i_start = 1'b0;
    i_par   = par;
    tick();
    tick();
    check_reset_vals({tag, " rst"});
    reset = 1'b0;
    #2;
    check_reset_vals({tag, " start"});
    tick();
  endtask

  typedef struct {
    logic [W-1:0] par_in;
    logic [W-1:0] par_late;
    bit           change_par;
    bit           pulse_start;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] rp;
    logic [W-1:0] rl;
    int           unstable;

    reset   = 1'b1;
    i_start = 1'b0;
    i_par   = '0;

    tbl[0] = '{16'hAA55, 16'h0000, 1'b0, 1'b0, 16'hAA55};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'hFFFF};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[3] = '{16'h1234, 16'hFFFF, 1'b1, 1'b0, 16'h1234};
    tbl[4] = '{16'h0F96, 16'h0000, 1'b0, 1'b1, 16'h0F96};

    for (int i = 0; i < 5; i++) begin
      reset_and_go(tbl[i].par_in, $sformatf("vec%0d", i));
      monitor_capture(tbl[i].exp_data, tbl[i].par_late, tbl[i].change_par,
                      tbl[i].pulse_start, $sformatf("vec%0d", i));
    end

    // Re-arm from DONE: word held while idle, then a new capture on i_start.
    reset_and_go(16'hAA55, "rearm0");
    monitor_capture(16'hAA55, '0, 1'b0, 1'b0, "rearm0");
    unstable = 0;
    for (int i = 0; i < 6; i++) begin
      i_par = 16'($urandom);
      tick();
      if (o_data !== 16'hAA55 || o_done !== 1'b1) unstable++;
    end
    check("hold in done", 32'(unstable), 32'd0);
    i_par   = 16'h5A3C;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("rearm done drop", 32'(o_done), 32'd0);
    monitor_capture(16'h5A3C, '0, 1'b0, 1'b0, "rearm1");

    // Reset asserted after the third serial bit aborts at once.
    reset_and_go(16'h8E71, "abort");
    for (int i = 0; i < 7; i++) tick();
    check("abort partial data", 32'(o_data == 16'h0000), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("abort async");
    reset_and_go(16'hC3A5, "after abort");
    monitor_capture(16'hC3A5, '0, 1'b0, 1'b0, "after abort");

    // Randomised captures against the reference timeline.
    for (int i = 0; i < 12; i++) begin
      rp = 16'($urandom);
      rl = 16'($urandom);
      if (i % 2 == 0) begin
        reset_and_go(rp, $sformatf("rnd%0d", i));
      end else begin
        i_par   = rp;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check($sformatf("rnd%0d rearm drop", i), 32'(o_done), 32'd0);
      end
      monitor_capture(rp, rl, 1'b1, ($urandom_range(0, 1) == 1), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
